axi_rd_resp_fifo: RTL and testbench

Read-data (R) channel buffer that sits directly downstream of the AXI interconnect's per-master R-channel outputs, between one interconnect slave port and the master it serves. It stores full R beats (id, data, resp, last, user) in a first-word-fall-through FIFO. It re-times the ready/valid handshake, and reports fill level, complete bursts held, and a sticky error flag for SLVERR/DECERR responses.

---
 rtl/axi_rd_resp_fifo.sv | 113 +++++++++++
 tb/tb_axi_rd_resp_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_resp_fifo.sv
// AXI read-data channel buffer: first-word-fall-through FIFO of full R beats with
// a registered head stage, fill/burst counters and a sticky error-response flag.
module axi_rd_resp_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 8,
    parameter int RUSER_WIDTH = 1,
    parameter int DEPTH       = 16,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ID_WIDTH-1:0]    m_axi_rid,
    input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic [RUSER_WIDTH-1:0] m_axi_ruser,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    output logic [ID_WIDTH-1:0]    s_axi_rid,
    output logic [DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rlast,
    output logic [RUSER_WIDTH-1:0] s_axi_ruser,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [CNT_W-1:0]       fill_count,
    output logic [CNT_W-1:0]       burst_count,
    output logic                   resp_err,
    input  logic                   err_clr
);

    localparam int PW = ID_WIDTH + DATA_WIDTH + 2 + 1 + RUSER_WIDTH;
    localparam int AW = CNT_W - 1;

    logic [PW-1:0]    mem_r [DEPTH];
    logic [PW-1:0]    out_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] wp_r;
    logic [CNT_W-1:0] rp_r;
    logic [CNT_W-1:0] burst_r;
    logic             err_r;

    logic [PW-1:0]    wdata_s;
    logic [CNT_W-1:0] fill_s;
    logic [CNT_W-1:0] rp_next_s;
    logic [CNT_W-1:0] burst_next_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             next_valid_s;

    assign wdata_s      = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser};
    assign fill_s       = wp_r - rp_r;
    assign full_s       = (fill_s == CNT_W'(DEPTH));
    // Ready depends only on registered pointers and is forced low while in reset.
    assign m_axi_rready = ~rst & ~full_s;
    assign push_s       = m_axi_rvalid & m_axi_rready;
    assign pop_s        = out_valid_r & s_axi_rready;
    assign rp_next_s    = rp_r + {{(CNT_W-1){1'b0}}, pop_s};
    // Head stage only reloads from entries written before this edge, never the incoming beat.
    assign next_valid_s = (wp_r != rp_next_s);

    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser} = out_r;
    assign s_axi_rvalid = out_valid_r;
    assign fill_count   = fill_s;
    assign burst_count  = burst_r;
    assign resp_err     = err_r;

    // Net change of the complete-burst counter from the push and pop of this cycle.
    always_comb begin
        burst_next_s = burst_r;
        case ({push_s & m_axi_rlast, pop_s & s_axi_rlast})
            2'b10:   burst_next_s = burst_r + CNT_W'(1);
            2'b01:   burst_next_s = burst_r - CNT_W'(1);
            default: burst_next_s = burst_r;
        endcase
    end

    // Beat storage array, written at the write pointer on each push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wp_r[AW-1:0]] <= wdata_s;
        end
    end

    // Pointers, counters, sticky error flag and registered head-of-FIFO stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r        <= '0;
            rp_r        <= '0;
            burst_r     <= '0;
            err_r       <= 1'b0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wp_r <= wp_r + CNT_W'(1);
            end
            rp_r        <= rp_next_s;
            burst_r     <= burst_next_s;
            out_valid_r <= next_valid_s;
            if (next_valid_s) begin
                out_r <= mem_r[rp_next_s[AW-1:0]];
            end
            if (push_s && m_axi_rresp[1]) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_resp_fifo.sv
// Directed self-checking bench for axi_rd_resp_fifo (DEPTH=16, 32-bit data, 8-bit id).
module tb_axi_rd_resp_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  m_axi_rid;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic [0:0]  m_axi_ruser;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic [0:0]  s_axi_ruser;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [4:0]  fill_count;
    logic [4:0]  burst_count;
    logic        resp_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    axi_rd_resp_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .m_axi_rid    (m_axi_rid),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_ruser  (m_axi_ruser),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_ruser  (s_axi_ruser),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .fill_count   (fill_count),
        .burst_count  (burst_count),
        .resp_err     (resp_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int          sent;
    int          recv;
    int          cyc;
    logic        held;
    logic [31:0] hold_data;
    logic [7:0]  hold_id;

    initial begin
        rst = 1'b1; m_axi_rid = 8'h00; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0; m_axi_ruser = 1'b0; m_axi_rvalid = 1'b1;
        s_axi_rready = 1'b0; err_clr = 1'b0;

        // Reset with upstream valid asserted
        @(negedge clk);
        repeat (3) begin
            chk("rst_mready", 64'(m_axi_rready), 64'd0);
            tick();
        end
        chk("rst_svalid", 64'(s_axi_rvalid), 64'd0);
        chk("rst_fill", 64'(fill_count), 64'd0);
        chk("rst_burst", 64'(burst_count), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        m_axi_rvalid = 1'b0;
        rst = 1'b0;
        #1 chk("rel_mready", 64'(m_axi_rready), 64'd1);
        tick();

        // Single beat
        m_axi_rid = 8'h05; m_axi_rdata = 32'hDEADBEEF; m_axi_rlast = 1'b1;
        m_axi_rvalid = 1'b1; s_axi_rready = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        chk("one_fill_a", 64'(fill_count), 64'd1);
        chk("one_valid_a", 64'(s_axi_rvalid), 64'd0);
        chk("one_burst", 64'(burst_count), 64'd1);
        tick();
        chk("one_valid_b", 64'(s_axi_rvalid), 64'd1);
        chk("one_id", 64'(s_axi_rid), 64'h05);
        chk("one_data", 64'(s_axi_rdata), 64'hDEADBEEF);
        chk("one_last", 64'(s_axi_rlast), 64'd1);
        chk("one_fill_b", 64'(fill_count), 64'd1);
        tick();
        chk("one_fill_c", 64'(fill_count), 64'd0);
        chk("one_valid_c", 64'(s_axi_rvalid), 64'd0);
        chk("one_burst_c", 64'(burst_count), 64'd0);

        // Fill to full with downstream stalled
        s_axi_rready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'(i); m_axi_rdata = 32'(i);
            m_axi_rlast = (i == 3 || i == 7 || i == 15);
            tick();
        end
        m_axi_rdata = 32'd99; m_axi_rlast = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        chk("full_fill", 64'(fill_count), 64'd16);
        chk("full_burst", 64'(burst_count), 64'd3);
        chk("full_mready", 64'(m_axi_rready), 64'd0);
        chk("full_head", 64'(s_axi_rdata), 64'd0);
        s_axi_rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", 64'(s_axi_rvalid), 64'd1);
            chk("drain_data", 64'(s_axi_rdata), 64'(i));
            tick();
            if (i == 0) chk("drain_mready", 64'(m_axi_rready), 64'd1);
        end
        chk("drain_fill", 64'(fill_count), 64'd0);
        chk("drain_burst", 64'(burst_count), 64'd0);
        chk("drain_valid_end", 64'(s_axi_rvalid), 64'd0);

        // Random backpressure stream of 64 beats
        sent = 0; recv = 0; cyc = 0; held = 1'b0; hold_data = 32'h0; hold_id = 8'h0;
        while (recv < 64 && cyc < 2000) begin
            if (held) begin
                chk("hold_valid", 64'(s_axi_rvalid), 64'd1);
                chk("hold_data", 64'(s_axi_rdata), 64'(hold_data));
                chk("hold_id", 64'(s_axi_rid), 64'(hold_id));
            end
            if (s_axi_rvalid) chk("order", 64'(s_axi_rdata), 64'(32'h1000 + 32'(recv)));
            s_axi_rready = 1'($urandom_range(0, 1));
            held = s_axi_rvalid && !s_axi_rready;
            hold_data = s_axi_rdata; hold_id = s_axi_rid;
            if (s_axi_rvalid && s_axi_rready) recv++;
            m_axi_rvalid = (sent < 64);
            m_axi_rdata = 32'h1000 + 32'(sent); m_axi_rid = 8'(sent);
            m_axi_rlast = (sent % 4 == 3);
            if (m_axi_rvalid && m_axi_rready) sent++;
            tick();
            cyc++;
        end
        m_axi_rvalid = 1'b0;
        chk("stream_recv", 64'(recv), 64'd64);
        tick();
        chk("stream_fill", 64'(fill_count), 64'd0);
        chk("stream_burst", 64'(burst_count), 64'd0);

        // Sticky error flag
        s_axi_rready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        m_axi_rresp = 2'b10; err_clr = 1'b1;
        tick();
        chk("err_set_wins", 64'(resp_err), 64'd1);
        m_axi_rresp = 2'b00;
        tick();
        chk("err_clear", 64'(resp_err), 64'd0);
        err_clr = 1'b0; m_axi_rresp = 2'b11;
        tick();
        chk("err_decerr", 64'(resp_err), 64'd1);
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
        repeat (4) tick();
        chk("err_sticky", 64'(resp_err), 64'd1);
        chk("err_fill", 64'(fill_count), 64'd0);

        // Continuous stream then asynchronous reset mid-burst
        for (int k = 0; k < 25; k++) begin
            s_axi_rready = (k >= 5);
            m_axi_rvalid = 1'b1; m_axi_rdata = 32'h2000 + 32'(k); m_axi_rid = 8'(k);
            m_axi_rlast = (k % 4 == 3);
            tick();
        end
        chk("wrap_fill", 64'(fill_count), 64'd5);
        chk("wrap_burst", 64'(burst_count), 64'd1);
        chk("wrap_head", 64'(s_axi_rdata), 64'h2014);
        rst = 1'b1;
        #1;
        chk("arst_fill", 64'(fill_count), 64'd0);
        chk("arst_burst", 64'(burst_count), 64'd0);
        chk("arst_valid", 64'(s_axi_rvalid), 64'd0);
        chk("arst_mready", 64'(m_axi_rready), 64'd0);
        chk("arst_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        tick();
        rst = 1'b0; m_axi_rvalid = 1'b0;
        tick();
        chk("post_valid", 64'(s_axi_rvalid), 64'd0);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE0001; m_axi_rid = 8'hA5;
        m_axi_rlast = 1'b1; s_axi_rready = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        chk("post_fill", 64'(fill_count), 64'd1);
        tick();
        chk("post_beat_valid", 64'(s_axi_rvalid), 64'd1);
        chk("post_beat_data", 64'(s_axi_rdata), 64'hCAFE0001);
        chk("post_beat_id", 64'(s_axi_rid), 64'hA5);
        tick();
        chk("post_empty_valid", 64'(s_axi_rvalid), 64'd0);
        chk("post_empty_fill", 64'(fill_count), 64'd0);
        tick();
        chk("post_no_stale", 64'(s_axi_rvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
